// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg
// Shared constants and types for the UART program loader:
//   - UART frame shape (8 data bits, 1 stop bit)
//   - instruction word shape (4 bytes per 32-bit word)
//   - receiver / loader state encoding
//   - place_byte(): drops one byte into a word at a byte lane
package prog_loader_pkg;

    localparam int DATA_BITS      = 8;
    localparam int STOP_BITS      = 1;
    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_BITS      = DATA_BITS * BYTES_PER_WORD;
    localparam int BYTE_IDX_BITS  = $clog2(BYTES_PER_WORD);

    // IDLE..STOP are walked by the byte receiver; LOADED is the loader's
    // terminal state once every memory word has been written.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        LOADED
    } rx_state_e;

    // Little-endian lane placement: lane 0 is bits [7:0].
    function automatic logic [WORD_BITS-1:0] place_byte(
        input logic [WORD_BITS-1:0]     word,
        input logic [BYTE_IDX_BITS-1:0] idx,
        input logic [DATA_BITS-1:0]     data
    );
        logic [WORD_BITS-1:0] result;
        result = word;
        result[idx*DATA_BITS +: DATA_BITS] = data;
        return result;
    endfunction

endpackage

// File: rtl/prog_loader_if.sv
// prog_loader_if
// Bundles the loader's serial input and its memory-write / status outputs.
//   rx         serial UART data into the loader (idle high)
//   mem_we     one-cycle write strobe
//   mem_waddr  word address of the write
//   mem_wdata  32-bit instruction word
//   core_hold  holds the core in reset until loading completes
//   done       all words written
//   frame_err  sticky stop-bit error flag
// master: the loader side.  slave: the memory / core / serial-source side.
interface prog_loader_if #(
    parameter int ADDR_BITS = 4
);
    import prog_loader_pkg::*;

    logic                 rx;
    logic                 mem_we;
    logic [ADDR_BITS-1:0] mem_waddr;
    logic [WORD_BITS-1:0] mem_wdata;
    logic                 core_hold;
    logic                 done;
    logic                 frame_err;

    modport master (
        input  rx,
        output mem_we, mem_waddr, mem_wdata, core_hold, done, frame_err
    );

    modport slave (
        output rx,
        input  mem_we, mem_waddr, mem_wdata, core_hold, done, frame_err
    );

endinterface

// File: rtl/prog_loader_uart_rx.sv
// uart_rx_byte
// 8N1 UART byte receiver: 2-flop synchronizer, bit timer and IDLE..STOP FSM.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   rx           raw serial input (asynchronous to clk)
//   rx_byte      last assembled byte (LSB received first)
//   byte_valid   one-cycle pulse in the cycle the good stop bit is sampled
//   byte_err     one-cycle pulse in the cycle a bad (low) stop bit is sampled
// The pulses are asserted in the sampling cycle itself so a registered
// consumer acts on them in the very next cycle.
module uart_rx_byte
    import prog_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_byte,
    output logic                 byte_valid,
    output logic                 byte_err
);

    localparam int TIMER_BITS  = $clog2(CLKS_PER_BIT);
    localparam int BITCNT_BITS = $clog2(DATA_BITS);
    localparam logic [TIMER_BITS-1:0]  BIT_LAST  = TIMER_BITS'(CLKS_PER_BIT - 1);
    localparam logic [TIMER_BITS-1:0]  HALF_LAST = TIMER_BITS'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BITCNT_BITS-1:0] LAST_BIT  = BITCNT_BITS'(DATA_BITS - 1);

    rx_state_e              state_q, state_d;
    logic                   rx_meta_q, rx_sync_q;
    logic [TIMER_BITS-1:0]  timer_q, timer_d;
    logic [BITCNT_BITS-1:0] bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   stop_ok, stop_bad;

    // Frame sequencing. The timer is held at zero in IDLE so START begins
    // counting from the first cycle the start bit is seen; START samples at
    // mid-bit and every later sample is a full bit period after that, which
    // keeps all samples centred on their bits.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q + 1'b1;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        stop_ok   = 1'b0;
        stop_bad  = 1'b0;
        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (!rx_sync_q) begin
                    state_d = START;
                end
            end
            START: begin
                if (timer_q == HALF_LAST) begin
                    timer_d   = '0;
                    bit_cnt_d = '0;
                    // A start bit that is high again at mid-bit was a glitch.
                    state_d   = rx_sync_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (timer_q == BIT_LAST) begin
                    timer_d = '0;
                    shift_d = {rx_sync_q, shift_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (timer_q == BIT_LAST) begin
                    timer_d = '0;
                    state_d = IDLE;
                    if (rx_sync_q) begin
                        stop_ok = 1'b1;
                    end else begin
                        stop_bad = 1'b1;
                    end
                end
            end
            default: begin
                timer_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Synchronizer flops reset to the idle-high line level so reset release
    // never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            state_q   <= IDLE;
            timer_q   <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
        end
    end

    assign rx_byte    = shift_q;
    assign byte_valid = stop_ok;
    assign byte_err   = stop_bad;

endmodule

// File: rtl/prog_loader.sv
// prog_loader
// Loads 2**ADDR_BITS little-endian 32-bit instruction words received over an
// 8N1 UART into instruction memory, holding the core in reset until done.
// Parameters:
//   CLKS_PER_BIT  clk cycles per UART bit (4..1024)
//   ADDR_BITS     word-address width of the instruction memory
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   bus           prog_loader_if master: rx in; mem_we, mem_waddr, mem_wdata,
//                 core_hold, done, frame_err out (all registered)
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int ADDR_BITS    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    prog_loader_if.master bus
);

    localparam logic [ADDR_BITS-1:0]     ADDR_LAST = {ADDR_BITS{1'b1}};
    localparam logic [BYTE_IDX_BITS-1:0] LAST_BYTE = BYTE_IDX_BITS'(BYTES_PER_WORD - 1);

    logic [DATA_BITS-1:0] rx_byte;
    logic                 byte_valid;
    logic                 byte_err;

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (bus.rx),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .byte_err   (byte_err)
    );

    rx_state_e              state_q, state_d;
    logic [BYTE_IDX_BITS-1:0] byte_cnt_q, byte_cnt_d;
    logic [WORD_BITS-1:0]   word_q, word_d;
    logic                   mem_we_q, mem_we_d;
    logic [ADDR_BITS-1:0]   mem_waddr_q, mem_waddr_d;
    logic [WORD_BITS-1:0]   mem_wdata_q, mem_wdata_d;
    logic                   core_hold_q, core_hold_d;
    logic                   done_q, done_d;
    logic                   frame_err_q, frame_err_d;

    // Word assembly, address counter and the terminal LOADED state.
    // The address advances in the cycle after each write strobe, so the
    // write at the last address naturally wraps the counter to 0 exactly as
    // LOADED is entered; LOADED then pins it there and ignores the receiver.
    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        word_d      = word_q;
        mem_we_d    = 1'b0;
        mem_waddr_d = mem_waddr_q;
        mem_wdata_d = mem_wdata_q;
        core_hold_d = core_hold_q;
        done_d      = done_q;
        frame_err_d = frame_err_q;

        if (state_q == LOADED) begin
            mem_waddr_d = '0;
        end else begin
            if (mem_we_q) begin
                mem_waddr_d = mem_waddr_q + 1'b1;
                if (mem_waddr_q == ADDR_LAST) begin
                    state_d     = LOADED;
                    done_d      = 1'b1;
                    core_hold_d = 1'b0;
                end
            end

            // A bad frame throws away the word in progress but keeps the
            // address, so the sender can simply resend that whole word.
            if (byte_err) begin
                frame_err_d = 1'b1;
                byte_cnt_d  = '0;
            end else if (byte_valid) begin
                if (byte_cnt_q == LAST_BYTE) begin
                    mem_we_d    = 1'b1;
                    mem_wdata_d = place_byte(word_q, LAST_BYTE, rx_byte);
                    byte_cnt_d  = '0;
                end else begin
                    word_d      = place_byte(word_q, byte_cnt_q, rx_byte);
                    byte_cnt_d  = byte_cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            byte_cnt_q  <= '0;
            word_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_waddr_q <= '0;
            mem_wdata_q <= '0;
            core_hold_q <= 1'b1;
            done_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            word_q      <= word_d;
            mem_we_q    <= mem_we_d;
            mem_waddr_q <= mem_waddr_d;
            mem_wdata_q <= mem_wdata_d;
            core_hold_q <= core_hold_d;
            done_q      <= done_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign bus.mem_we    = mem_we_q;
    assign bus.mem_waddr = mem_waddr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.core_hold = core_hold_q;
    assign bus.done      = done_q;
    assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader
// Self-checking bench for prog_loader. Three instances share clk/rst_n:
//   sel 0: CLKS_PER_BIT=16 (main scenarios), sel 1: 4, sel 2: 1024.
// A table of 16 words (bytes + hand-computed little-endian word) drives the
// full load; hand-written sequences cover reset, glitch and framing errors.
module tb_prog_loader;
    import prog_loader_pkg::*;

    localparam int AB     = 4;
    localparam int NWORDS = 1 << AB;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    prog_loader_if #(.ADDR_BITS(AB)) bus16 ();
    prog_loader_if #(.ADDR_BITS(AB)) bus4 ();
    prog_loader_if #(.ADDR_BITS(AB)) bus1k ();

    prog_loader #(.CLKS_PER_BIT(16), .ADDR_BITS(AB)) dut16 (
        .clk (clk), .rst_n (rst_n), .bus (bus16.master)
    );
    prog_loader #(.CLKS_PER_BIT(4), .ADDR_BITS(AB)) dut4 (
        .clk (clk), .rst_n (rst_n), .bus (bus4.master)
    );
    prog_loader #(.CLKS_PER_BIT(1024), .ADDR_BITS(AB)) dut1k (
        .clk (clk), .rst_n (rst_n), .bus (bus1k.master)
    );

    typedef struct packed {
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
        logic [7:0]  b3;
        logic [31:0] word;
    } word_vec_t;

    int checks   = 0;
    int failures = 0;

    // Captured writes per instance.
    int              wr_count [3];
    logic [AB-1:0]   wr_addr  [3][32];
    logic [31:0]     wr_data  [3][32];
    logic            last_write_seen = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    // Write capture, plus the completion timing around the final write.
    always @(negedge clk) begin
        if (last_write_seen) begin
            checkOutput("done_after_last_write", 32'(bus16.done), 32'd1);
            checkOutput("hold_after_last_write", 32'(bus16.core_hold), 32'd0);
            checkOutput("addr_wrap_after_last", 32'(bus16.mem_waddr), 32'd0);
        end
        last_write_seen = 1'b0;
        if (bus16.mem_we) begin
            if (wr_count[0] < 32) begin
                wr_addr[0][wr_count[0]] = bus16.mem_waddr;
                wr_data[0][wr_count[0]] = bus16.mem_wdata;
            end
            wr_count[0]++;
            if (bus16.mem_waddr == AB'(NWORDS - 1)) begin
                checkOutput("done_low_during_last_write", 32'(bus16.done), 32'd0);
                last_write_seen = 1'b1;
            end
        end
        if (bus4.mem_we) begin
            if (wr_count[1] < 32) begin
                wr_addr[1][wr_count[1]] = bus4.mem_waddr;
                wr_data[1][wr_count[1]] = bus4.mem_wdata;
            end
            wr_count[1]++;
        end
        if (bus1k.mem_we) begin
            if (wr_count[2] < 32) begin
                wr_addr[2][wr_count[2]] = bus1k.mem_waddr;
                wr_data[2][wr_count[2]] = bus1k.mem_wdata;
            end
            wr_count[2]++;
        end
    end

    function automatic int cpb_of(input int sel);
        case (sel)
            0:       return 16;
            1:       return 4;
            default: return 1024;
        endcase
    endfunction

    task automatic set_rx(input int sel, input logic v);
        case (sel)
            0:       bus16.rx = v;
            1:       bus4.rx  = v;
            default: bus1k.rx = v;
        endcase
    endtask

    task automatic send_bit(input int sel, input logic v);
        set_rx(sel, v);
        repeat (cpb_of(sel)) @(negedge clk);
    endtask

    // One 8N1 frame, LSB first, with a chosen stop-bit level.
    task automatic applyStimulus(input int sel, input logic [7:0] data, input logic stop_bit);
        send_bit(sel, 1'b0);
        for (int i = 0; i < 8; i++) begin
            send_bit(sel, data[i]);
        end
        send_bit(sel, stop_bit);
        set_rx(sel, 1'b1);
    endtask

    task automatic send_word(input int sel, input word_vec_t v);
        applyStimulus(sel, v.b0, 1'b1);
        applyStimulus(sel, v.b1, 1'b1);
        applyStimulus(sel, v.b2, 1'b1);
        applyStimulus(sel, v.b3, 1'b1);
    endtask

    task automatic idle_bits(input int sel, input int n);
        for (int i = 0; i < n; i++) begin
            send_bit(sel, 1'b1);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checkOutput({tag, "_we"},    32'(bus16.mem_we),    32'd0);
        checkOutput({tag, "_waddr"}, 32'(bus16.mem_waddr), 32'd0);
        checkOutput({tag, "_wdata"}, bus16.mem_wdata,      32'd0);
        checkOutput({tag, "_hold"},  32'(bus16.core_hold), 32'd1);
        checkOutput({tag, "_done"},  32'(bus16.done),      32'd0);
        checkOutput({tag, "_ferr"},  32'(bus16.frame_err), 32'd0);
    endtask

    // Drives reset for a few cycles, checks the held outputs, releases it and
    // clears the write capture.
    task automatic do_reset(input string tag);
        set_rx(0, 1'b1);
        set_rx(1, 1'b1);
        set_rx(2, 1'b1);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs(tag);
        for (int i = 0; i < 3; i++) begin
            wr_count[i] = 0;
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    word_vec_t table_v [NWORDS];

    initial begin
        table_v[0]  = '{8'h13, 8'h00, 8'h10, 8'h00, 32'h00100013};
        table_v[1]  = '{8'h93, 8'h00, 8'h10, 8'h00, 32'h00100093};
        table_v[2]  = '{8'h13, 8'h01, 8'h20, 8'h00, 32'h00200113};
        table_v[3]  = '{8'hb3, 8'h01, 8'h11, 8'h40, 32'h401101b3};
        table_v[4]  = '{8'h23, 8'h20, 8'h20, 8'h00, 32'h00202023};
        table_v[5]  = '{8'h6f, 8'h00, 8'h00, 8'h00, 32'h0000006f};
        table_v[6]  = '{8'hef, 8'hbe, 8'had, 8'hde, 32'hdeadbeef};
        table_v[7]  = '{8'h78, 8'h56, 8'h34, 8'h12, 32'h12345678};
        table_v[8]  = '{8'hff, 8'hff, 8'hff, 8'hff, 32'hffffffff};
        table_v[9]  = '{8'h00, 8'h00, 8'h00, 8'h00, 32'h00000000};
        table_v[10] = '{8'h01, 8'h02, 8'h03, 8'h04, 32'h04030201};
        table_v[11] = '{8'haa, 8'hbb, 8'hcc, 8'hdd, 32'hddccbbaa};
        table_v[12] = '{8'h55, 8'haa, 8'h55, 8'haa, 32'haa55aa55};
        table_v[13] = '{8'h80, 8'h00, 8'h00, 8'h01, 32'h01000080};
        table_v[14] = '{8'h01, 8'h00, 8'h00, 8'h80, 32'h80000001};
        table_v[15] = '{8'h67, 8'h80, 8'h00, 8'h00, 32'h00008067};

        for (int i = 0; i < 3; i++) begin
            wr_count[i] = 0;
        end
        bus16.rx = 1'b1;
        bus4.rx  = 1'b1;
        bus1k.rx = 1'b1;
        @(negedge clk);

        // Reset state.
        do_reset("reset");

        // Single word 0x00100013.
        send_word(0, table_v[0]);
        idle_bits(0, 2);
        checkOutput("w1_count", 32'(wr_count[0]), 32'd1);
        checkOutput("w1_addr", 32'(wr_addr[0][0]), 32'd0);
        checkOutput("w1_data", wr_data[0][0], 32'h00100013);
        checkOutput("w1_done", 32'(bus16.done), 32'd0);
        checkOutput("w1_hold", 32'(bus16.core_hold), 32'd1);
        checkOutput("w1_addr_next", 32'(bus16.mem_waddr), 32'd1);
        checkOutput("w1_wdata_held", bus16.mem_wdata, 32'h00100013);

        // Reset after two bytes (and mid-way through a third) drops the
        // partial word and the address.
        applyStimulus(0, 8'haa, 1'b1);
        applyStimulus(0, 8'hbb, 1'b1);
        set_rx(0, 1'b0);
        repeat (40) @(negedge clk);
        do_reset("midword_reset");
        applyStimulus(0, 8'h01, 1'b1);
        applyStimulus(0, 8'h02, 1'b1);
        applyStimulus(0, 8'h03, 1'b1);
        applyStimulus(0, 8'h04, 1'b1);
        idle_bits(0, 2);
        checkOutput("rst_count", 32'(wr_count[0]), 32'd1);
        checkOutput("rst_addr", 32'(wr_addr[0][0]), 32'd0);
        checkOutput("rst_data", wr_data[0][0], 32'h04030201);
        checkOutput("rst_ferr", 32'(bus16.frame_err), 32'd0);

        // Start-bit glitch of a quarter bit is rejected silently.
        do_reset("glitch_reset");
        set_rx(0, 1'b0);
        repeat (4) @(negedge clk);
        set_rx(0, 1'b1);
        idle_bits(0, 3);
        checkOutput("glitch_count", 32'(wr_count[0]), 32'd0);
        checkOutput("glitch_ferr", 32'(bus16.frame_err), 32'd0);
        checkOutput("glitch_state", 32'(dut16.u_rx.state_q), 32'(IDLE));
        send_word(0, table_v[7]);
        idle_bits(0, 2);
        checkOutput("glitch_then_word_count", 32'(wr_count[0]), 32'd1);
        checkOutput("glitch_then_word_data", wr_data[0][0], 32'h12345678);

        // Bad stop bit mid-word: flag set, partial word discarded, loading
        // continues at the same address.
        do_reset("ferr_reset");
        applyStimulus(0, 8'h11, 1'b1);
        applyStimulus(0, 8'h5a, 1'b0);
        idle_bits(0, 2);
        checkOutput("ferr_set", 32'(bus16.frame_err), 32'd1);
        checkOutput("ferr_no_write", 32'(wr_count[0]), 32'd0);
        send_word(0, table_v[11]);
        idle_bits(0, 2);
        checkOutput("ferr_count", 32'(wr_count[0]), 32'd1);
        checkOutput("ferr_addr", 32'(wr_addr[0][0]), 32'd0);
        checkOutput("ferr_data", wr_data[0][0], 32'hddccbbaa);
        checkOutput("ferr_sticky", 32'(bus16.frame_err), 32'd1);

        // Full load: 64 back-to-back bytes from the table.
        do_reset("load_reset");
        for (int w = 0; w < NWORDS; w++) begin
            send_word(0, table_v[w]);
        end
        idle_bits(0, 2);
        checkOutput("load_count", 32'(wr_count[0]), 32'(NWORDS));
        for (int w = 0; w < NWORDS; w++) begin
            checkOutput($sformatf("load_addr_%0d", w), 32'(wr_addr[0][w]), 32'(w));
            checkOutput($sformatf("load_data_%0d", w), wr_data[0][w], table_v[w].word);
        end
        checkOutput("load_done", 32'(bus16.done), 32'd1);
        checkOutput("load_hold", 32'(bus16.core_hold), 32'd0);

        // LOADED ignores further traffic, including bad frames.
        send_word(0, table_v[6]);
        applyStimulus(0, 8'h3c, 1'b0);
        idle_bits(0, 2);
        checkOutput("loaded_no_more_writes", 32'(wr_count[0]), 32'(NWORDS));
        checkOutput("loaded_addr_zero", 32'(bus16.mem_waddr), 32'd0);
        checkOutput("loaded_done_kept", 32'(bus16.done), 32'd1);
        checkOutput("loaded_ferr_clear", 32'(bus16.frame_err), 32'd0);
        checkOutput("loaded_wdata_kept", bus16.mem_wdata, 32'h00008067);

        // Same single word at the extreme bit rates.
        do_reset("rate_reset");
        fork
            begin
                send_word(1, table_v[0]);
                idle_bits(1, 2);
            end
            begin
                send_word(2, table_v[0]);
                idle_bits(2, 2);
            end
        join
        checkOutput("cpb4_count", 32'(wr_count[1]), 32'd1);
        checkOutput("cpb4_addr", 32'(wr_addr[1][0]), 32'd0);
        checkOutput("cpb4_data", wr_data[1][0], 32'h00100013);
        checkOutput("cpb4_done", 32'(bus4.done), 32'd0);
        checkOutput("cpb1024_count", 32'(wr_count[2]), 32'd1);
        checkOutput("cpb1024_addr", 32'(wr_addr[2][0]), 32'd0);
        checkOutput("cpb1024_data", wr_data[2][0], 32'h00100013);
        checkOutput("cpb1024_done", 32'(bus1k.done), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Guard against a stuck run.
    initial begin
        repeat (200000) @(posedge clk);
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: clk cycles per UART bit; legal range 4..1024.
REQ-002 Parameter ADDR_BITS, default 4: word-address width of the instruction memory (2**ADDR_BITS words).
REQ-003 clk  input  1  single clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 rx  input  1  UART 8N1 serial data, idle high, asynchronous to clk.
REQ-006 mem_we  output  1  one-cycle write strobe to instruction memory.
REQ-007 mem_waddr  output  ADDR_BITS  word address for the write.
REQ-008 mem_wdata  output  32  instruction word for the write.
REQ-009 core_hold  output  1  high holds the core in reset until loading is complete.
REQ-010 done  output  1  high once all 2**ADDR_BITS words are written.
REQ-011 frame_err  output  1  sticky flag, set on any stop-bit error.

Function
REQ-012 rx shall pass through a 2-flop synchronizer, both flops reset to 1; all sampling uses the synchronized value.
REQ-013 Receiver FSM states shall be IDLE, START, DATA, STOP, LOADED.
REQ-014 IDLE: on synchronized rx = 0, go to START and clear the bit-timer.
REQ-015 START: after CLKS_PER_BIT/2 cycles, sample rx; 0 -> DATA, 1 -> IDLE (glitch rejected, no error).
REQ-016 DATA: sample one bit every CLKS_PER_BIT cycles; 8 bits, LSB first, into a byte shift register; then go to STOP.
REQ-017 STOP: after CLKS_PER_BIT cycles, sample rx; 1 -> byte valid; 0 -> set frame_err, discard the byte, reset the byte counter to 0, keep mem_waddr; either case returns to IDLE.
REQ-018 Valid bytes shall be assembled little-endian: byte counter 0..3 fills word bits [7:0], [15:8], [23:16], [31:24].
REQ-019 On the 4th valid byte, mem_we shall be 1 for exactly the cycle after the stop-bit sample, with mem_wdata = assembled word and mem_waddr = current address.
REQ-020 mem_waddr shall increment by 1 the cycle after each write; mem_wdata shall hold its value between writes.
REQ-021 After the write at address 2**ADDR_BITS-1, FSM shall enter LOADED the next cycle, with done = 1 and core_hold = 0 in that same cycle.
REQ-022 LOADED shall be terminal: rx is ignored, mem_we stays 0, and mem_waddr wraps to 0 and holds there until reset.
REQ-023 A new start bit shall be accepted in IDLE the cycle after STOP completes (back-to-back bytes, no idle gap required).
REQ-024 frame_err shall remain set until reset and shall not stop loading.

Reset
REQ-025 While rst_n = 0: FSM = IDLE, counters = 0, mem_we = 0, mem_waddr = 0, mem_wdata = 0, core_hold = 1, done = 0, frame_err = 0.
REQ-026 Reset asserted mid-byte or mid-word shall discard all partial data; loading restarts at address 0.
REQ-027 Reset release is synchronous to clk; the first start-bit detection is possible 3 cycles after deassertion.

Structure
REQ-028 FSM state encoding, UART frame constants (8 data bits, 1 stop) and the bytes-per-word constant (4) shall live in a shared package.
REQ-029 One sub-module, uart_rx_byte, shall hold the synchronizer, bit timer and IDLE..STOP FSM, and output a byte plus a one-cycle valid or frame-error pulse; prog_loader holds word assembly, address counter and LOADED logic.

Verification
REQ-030 Send bytes 0x13,0x00,0x10,0x00 -> one mem_we pulse, mem_waddr=0, mem_wdata=0x00100013, done=0.
REQ-031 Send 64 back-to-back valid bytes (ADDR_BITS=4) -> 16 mem_we pulses at addresses 0..15 in order; done=1 and core_hold=0 the cycle after the 16th write; later bytes produce no mem_we.
REQ-032 Send one byte with stop bit 0, then 4 valid bytes 0xAA,0xBB,0xCC,0xDD -> frame_err=1, single write at address 0 of 0xDDCCBBAA.
REQ-033 Drive rx low for CLKS_PER_BIT/4 cycles, then high -> no byte received, frame_err=0, FSM back to IDLE.
REQ-034 Assert rst_n low after 2 bytes of a word, release, then send 4 bytes 0x01,0x02,0x03,0x04 -> write at address 0 of 0x04030201, frame_err=0.
REQ-035 Run REQ-030 at CLKS_PER_BIT=4 and 1024 -> identical results.
